// File: rtl/mic_level_meter_if.sv
// rtl/mic_level_meter_if.sv - sample strobe, freeze control and published level bundle
interface mic_level_meter_if;
   logic        sample_valid;
   logic [11:0] mic_in;
   logic        freeze;
   logic [3:0]  volume_level;
   logic [10:0] peak_out;
   logic        level_valid;

   modport master (
      output sample_valid, mic_in, freeze,
      input  volume_level, peak_out, level_valid
   );

   modport slave (
      input  sample_valid, mic_in, freeze,
      output volume_level, peak_out, level_valid
   );
endinterface

// File: rtl/mic_level_meter.sv
// rtl/mic_level_meter.sv - windowed peak meter with instant attack, stepped release and freeze
module mic_level_meter #(
   parameter int WINDOW_SAMPLES = 4000,
   parameter int MIDPOINT       = 2048,
   parameter int RELEASE_STEP   = 1
) (
   input  logic               clk,
   input  logic               rst_n,
   mic_level_meter_if.slave   bus
);
   localparam int CW = (WINDOW_SAMPLES > 2) ? $clog2(WINDOW_SAMPLES) : 1;
   localparam logic [CW-1:0]     LAST_CNT = CW'(WINDOW_SAMPLES - 1);
   localparam logic signed [12:0] MID     = 13'(MIDPOINT);
   localparam logic [3:0]         STEP    = 4'(RELEASE_STEP);

   typedef enum logic {ACCUM, PUBLISH} state_t;

   state_t        state;
   logic [CW-1:0] cnt;
   logic [10:0]   win_max;
   logic [10:0]   cand_q;
   logic [3:0]    volume_level;
   logic [10:0]   peak_out;
   logic          level_valid;

   logic signed [12:0] diff;
   logic [12:0]        abs_v;
   logic [10:0]        mag;
   logic [10:0]        running_max;
   logic [3:0]         raw;
   logic [3:0]         dec;
   logic [3:0]         smoothed;

   always_comb begin
      diff  = $signed({1'b0, bus.mic_in}) - MID;
      abs_v = diff[12] ? $unsigned(-diff) : $unsigned(diff);
      mag   = (abs_v > 13'd2047) ? 11'h7ff : abs_v[10:0];
      running_max = (mag > win_max) ? mag : win_max;
   end

   // Release steps down by at most STEP per window but never below the new raw level.
   always_comb begin
      raw      = cand_q[10:7];
      dec      = (volume_level > STEP) ? (volume_level - STEP) : 4'd0;
      smoothed = volume_level;
      if (raw >= volume_level) begin
         smoothed = raw;
      end else begin
         smoothed = (raw > dec) ? raw : dec;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= ACCUM;
         cnt          <= '0;
         win_max      <= '0;
         cand_q       <= '0;
         volume_level <= '0;
         peak_out     <= '0;
         level_valid  <= 1'b0;
      end else begin
         level_valid <= 1'b0;

         if (state == PUBLISH) begin
            state <= ACCUM;
            if (!bus.freeze) begin
               volume_level <= smoothed;
               peak_out     <= cand_q;
               level_valid  <= 1'b1;
            end
         end

         // Samples are accepted in either state so a strobe during PUBLISH opens the next window.
         if (bus.sample_valid) begin
            if (cnt == LAST_CNT) begin
               cand_q  <= running_max;
               win_max <= '0;
               cnt     <= '0;
               state   <= PUBLISH;
            end else begin
               win_max <= running_max;
               cnt     <= cnt + 1'b1;
            end
         end
      end
   end

   assign bus.volume_level = volume_level;
   assign bus.peak_out     = peak_out;
   assign bus.level_valid  = level_valid;
endmodule

// File: tb/tb_mic_level_meter.sv
// tb/tb_mic_level_meter.sv - directed self-checking bench for mic_level_meter
module tb_mic_level_meter;
   logic clk;
   logic rst_n;
   int   checks;
   int   errors;
   int   pulses;
   logic [10:0] pub_peak[$];
   logic [3:0]  pub_vol[$];

   mic_level_meter_if bus ();

   mic_level_meter #(
      .WINDOW_SAMPLES(4),
      .MIDPOINT(2048),
      .RELEASE_STEP(1)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .bus(bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (bus.level_valid) begin
         pulses++;
         pub_peak.push_back(bus.peak_out);
         pub_vol.push_back(bus.volume_level);
      end
   end

   task automatic send_sample(input logic [11:0] s);
      @(negedge clk);
      bus.sample_valid = 1'b1;
      bus.mic_in       = s;
      @(negedge clk);
      bus.sample_valid = 1'b0;
   endtask

   task automatic send_window(input logic [11:0] a, input logic [11:0] b,
                              input logic [11:0] c, input logic [11:0] d);
      send_sample(a);
      send_sample(b);
      send_sample(c);
      send_sample(d);
   endtask

   task automatic apply_reset();
      @(negedge clk);
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      int base;
      bus.sample_valid = 1'b0;
      bus.mic_in       = 12'd2048;
      bus.freeze       = 1'b0;
      rst_n            = 1'b0;
      repeat (3) @(negedge clk);
      checks++;
      if (bus.volume_level !== 4'd0 || bus.peak_out !== 11'd0 || bus.level_valid !== 1'b0) begin
         errors++;
         $display("FAIL reset_hold: vol=%0d peak=%0d lv=%0b required 0 0 0",
                  bus.volume_level, bus.peak_out, bus.level_valid);
      end
      base = pulses;
      rst_n = 1'b1;
      repeat (10) @(negedge clk);
      checks++;
      if (bus.volume_level !== 4'd0 || bus.peak_out !== 11'd0) begin
         errors++;
         $display("FAIL reset_idle: vol=%0d peak=%0d required 0 0", bus.volume_level, bus.peak_out);
      end
      checks++;
      if (pulses - base !== 0) begin
         errors++;
         $display("FAIL reset_no_pulse: pulses=%0d required 0", pulses - base);
      end
   endtask

   task automatic test_attack();
      int base;
      base = pulses;
      send_window(12'd2048, 12'd2048, 12'd3000, 12'd2048);
      @(negedge clk);
      checks++;
      if (bus.level_valid !== 1'b1 || bus.peak_out !== 11'd952 || bus.volume_level !== 4'd7) begin
         errors++;
         $display("FAIL attack: lv=%0b peak=%0d vol=%0d required 1 952 7",
                  bus.level_valid, bus.peak_out, bus.volume_level);
      end
      repeat (4) @(negedge clk);
      checks++;
      if (pulses - base !== 1) begin
         errors++;
         $display("FAIL attack_pulses: pulses=%0d required 1", pulses - base);
      end
   endtask

   task automatic test_saturation();
      send_window(12'd2048, 12'd2048, 12'd2048, 12'd0);
      @(negedge clk);
      checks++;
      if (bus.peak_out !== 11'd2047 || bus.volume_level !== 4'd15) begin
         errors++;
         $display("FAIL sat_low: peak=%0d vol=%0d required 2047 15", bus.peak_out, bus.volume_level);
      end
      send_window(12'd2048, 12'd2048, 12'd2048, 12'd4095);
      @(negedge clk);
      checks++;
      if (bus.peak_out !== 11'd2047 || bus.volume_level !== 4'd15 || bus.level_valid !== 1'b1) begin
         errors++;
         $display("FAIL sat_high: peak=%0d vol=%0d lv=%0b required 2047 15 1",
                  bus.peak_out, bus.volume_level, bus.level_valid);
      end
   endtask

   task automatic test_release();
      logic [3:0] exp_vol;
      exp_vol = 4'd15;
      for (int w = 0; w < 4; w++) begin
         exp_vol = exp_vol - 4'd1;
         send_window(12'd2048, 12'd2048, 12'd2048, 12'd2048);
         @(negedge clk);
         checks++;
         if (bus.volume_level !== exp_vol || bus.peak_out !== 11'd0) begin
            errors++;
            $display("FAIL release_%0d: vol=%0d peak=%0d required %0d 0",
                     w, bus.volume_level, bus.peak_out, exp_vol);
         end
      end
   endtask

   task automatic test_freeze();
      int base;
      apply_reset();
      send_window(12'd2048, 12'd3000, 12'd2048, 12'd2048);
      repeat (2) @(negedge clk);
      base = pulses;
      bus.freeze = 1'b1;
      send_window(12'd3800, 12'd3800, 12'd3800, 12'd3800);
      repeat (3) @(negedge clk);
      checks++;
      if (bus.volume_level !== 4'd7 || bus.peak_out !== 11'd952 || pulses - base !== 0) begin
         errors++;
         $display("FAIL freeze_hold: vol=%0d peak=%0d pulses=%0d required 7 952 0",
                  bus.volume_level, bus.peak_out, pulses - base);
      end
      bus.freeze = 1'b0;
      send_window(12'd2048, 12'd2048, 12'd2048, 12'd2048);
      @(negedge clk);
      checks++;
      if (bus.volume_level !== 4'd6 || bus.peak_out !== 11'd0 || bus.level_valid !== 1'b1) begin
         errors++;
         $display("FAIL freeze_release: vol=%0d peak=%0d lv=%0b required 6 0 1",
                  bus.volume_level, bus.peak_out, bus.level_valid);
      end
   endtask

   task automatic test_back_to_back();
      logic [11:0] stim[12];
      logic [10:0] exp_peak[3];
      logic [3:0]  exp_vol[3];
      int base;
      int qbase;
      stim = '{12'd2048, 12'd2348, 12'd2048, 12'd2048,
               12'd2748, 12'd2048, 12'd2048, 12'd2048,
               12'd2048, 12'd2048, 12'd2048, 12'd1048};
      exp_peak = '{11'd300, 11'd700, 11'd1000};
      exp_vol  = '{4'd2, 4'd5, 4'd7};
      apply_reset();
      base  = pulses;
      qbase = pub_peak.size();
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         bus.sample_valid = 1'b1;
         bus.mic_in       = stim[i];
      end
      @(negedge clk);
      bus.sample_valid = 1'b0;
      repeat (4) @(negedge clk);
      checks++;
      if (pulses - base !== 3) begin
         errors++;
         $display("FAIL b2b_pulses: pulses=%0d required 3", pulses - base);
      end
      for (int w = 0; w < 3; w++) begin
         checks++;
         if (pub_peak.size() <= qbase + w) begin
            errors++;
            $display("FAIL b2b_win_%0d: no publish recorded, required peak %0d", w, exp_peak[w]);
         end else if (pub_peak[qbase+w] !== exp_peak[w] || pub_vol[qbase+w] !== exp_vol[w]) begin
            errors++;
            $display("FAIL b2b_win_%0d: peak=%0d vol=%0d required %0d %0d",
                     w, pub_peak[qbase+w], pub_vol[qbase+w], exp_peak[w], exp_vol[w]);
         end
      end
   endtask

   task automatic test_reset_mid_window();
      int base;
      send_sample(12'd3800);
      send_sample(12'd3800);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      checks++;
      if (bus.volume_level !== 4'd0 || bus.peak_out !== 11'd0 || bus.level_valid !== 1'b0) begin
         errors++;
         $display("FAIL mid_reset_async: vol=%0d peak=%0d lv=%0b required 0 0 0",
                  bus.volume_level, bus.peak_out, bus.level_valid);
      end
      @(negedge clk);
      rst_n = 1'b1;
      base = pulses;
      send_sample(12'd2048);
      send_sample(12'd2048);
      send_sample(12'd2048);
      repeat (3) @(negedge clk);
      checks++;
      if (pulses - base !== 0) begin
         errors++;
         $display("FAIL mid_reset_early: pulses=%0d required 0", pulses - base);
      end
      send_sample(12'd2448);
      @(negedge clk);
      checks++;
      if (bus.level_valid !== 1'b1 || bus.peak_out !== 11'd400 || bus.volume_level !== 4'd3) begin
         errors++;
         $display("FAIL mid_reset_fresh: lv=%0b peak=%0d vol=%0d required 1 400 3",
                  bus.level_valid, bus.peak_out, bus.volume_level);
      end
   endtask

   initial begin
      checks = 0;
      errors = 0;
      pulses = 0;
      test_reset();
      test_attack();
      test_saturation();
      test_release();
      test_freeze();
      test_back_to_back();
      test_reset_mid_window();
      repeat (2) @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
